noc_inject_scheduler: RTL and testbench

//  Queues packet-injection requests (target router + 8-bit payload) and presents

---
 rtl/noc_inject_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_noc_inject_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_scheduler.sv
// noc_inject_scheduler: queues router-targeted injection requests and presents them one at a time on the NoC injection bus.
// Latency: request handshake in cycle c -> packet on o_out_bus in cycle c+2 when idle and empty; ack -> GAP_CYC idle cycles.
// Backpressure: o_req_ready = !full; a packet holds its slot until acked (or, with NOC_INJ_TIMEOUT_EN, until TIMEOUT cycles pass).

// Generic synchronous FIFO with a combinational head read; pushes are ignored when full and pops when empty.
module noc_inj_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_vld,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push_vld & ~o_full;
    assign w_pop      = i_pop_vld & ~o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];

    // Storage array: written on accepted push only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// Optional ack timeout is enabled by defining NOC_INJ_TIMEOUT_EN.
module noc_inject_scheduler #(
    parameter int NR      = 9,
    parameter int PW      = 9,
    parameter int RW      = 4,
    parameter int DEPTH   = 4,
    parameter int GAP_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_req_valid,
    input  logic [RW-1:0]    i_req_router,
    input  logic [PW-2:0]    i_req_data,
    output logic             o_req_ready,
    input  logic [NR-1:0]    i_rtr_ack,
    output logic [NR*PW-1:0] o_out_bus,
    output logic             o_busy,
    output logic             o_bad_router,
    output logic [7:0]       o_sent_cnt,
    output logic             o_timeout
);
    typedef struct packed {
        logic [RW-1:0] router;
        logic [PW-2:0] data;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NR*PW-1:0] r_out_bus;
    logic [RW-1:0]    r_slot;
    logic [7:0]       r_sent_cnt;
    logic             r_bad_router;
    logic [GW-1:0]    r_gap_cnt;

    req_t             w_req;
    req_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_in_range;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic             w_release;
    logic             w_sent_inc;
    logic             w_ack_hit;
    logic             w_to_hit;
    logic             w_gap_done;
    logic [NR-1:0]    w_slot_mask;
    logic [NR*PW-1:0] w_launch_bus;

    // Out-of-range targets are still consumed so a bad source cannot wedge the queue.
    assign w_in_range = (i_req_router < RW'(NR));
    assign w_push     = i_req_valid & o_req_ready & w_in_range;
    assign w_drop     = i_req_valid & o_req_ready & ~w_in_range;
    assign w_req      = '{router: i_req_router, data: i_req_data};

    noc_inj_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push_vld (w_push),
        .i_push_dat (w_req),
        .i_pop_vld  (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Only the ack from the router currently being driven counts.
    assign w_slot_mask = NR'(1) << r_slot;
    assign w_ack_hit   = (r_state == S_DRIVE) & (|(i_rtr_ack & w_slot_mask));
    assign w_gap_done  = (r_gap_cnt == GW'(GAP_LAST));

`ifdef NOC_INJ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout;

    // An ack on the final wait cycle wins over the timeout.
    assign w_to_hit = (r_state == S_DRIVE) & ~w_ack_hit & (r_wait_cnt == TW'(TIMEOUT - 1));

    // Wait counter restarts on every launch; timeout pulse lands with the cleared bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (w_pop) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_DRIVE) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Build the launch image: head payload with valid flag in its router slot, others zero.
    always_comb begin
        w_launch_bus = '0;
        for (int i = 0; i < NR; i++) begin
            if (w_head.router == RW'(i)) begin
                w_launch_bus[i*PW +: PW] = {1'b1, w_head.data};
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes: launch from IDLE, release on ack/timeout, then gap.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_release   = 1'b0;
        w_sent_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (w_ack_hit || w_to_hit) begin
                    w_release   = 1'b1;
                    w_sent_inc  = w_ack_hit;
                    w_state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered bus, slot tracking, sent counter, drop pulse and gap counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_bus    <= '0;
            r_slot       <= '0;
            r_sent_cnt   <= '0;
            r_bad_router <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            r_bad_router <= w_drop;
            if (w_pop) begin
                r_out_bus <= w_launch_bus;
                r_slot    <= w_head.router;
            end else if (w_release) begin
                r_out_bus <= '0;
            end
            if (w_sent_inc) begin
                r_sent_cnt <= r_sent_cnt + 8'd1;
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign o_req_ready  = ~w_full;
    assign o_out_bus    = r_out_bus;
    assign o_busy       = (r_state != S_IDLE) | ~w_empty;
    assign o_bad_router = r_bad_router;
    assign o_sent_cnt   = r_sent_cnt;
endmodule

// File: tb/tb_noc_inject_scheduler.sv
// tb_noc_inject_scheduler: directed bench for the NoC injection scheduler.
// Latency: inputs driven 1 ns after each rising edge, outputs sampled there too.
// Backpressure: exercises full-queue refusal, wrong-router acks and held packets.
module tb_noc_inject_scheduler;
    localparam int NR  = 9;
    localparam int PW  = 9;
    localparam int RW  = 4;
    localparam int GAP = 2;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_en;
    logic             i_req_valid;
    logic [RW-1:0]    i_req_router;
    logic [PW-2:0]    i_req_data;
    logic             o_req_ready;
    logic [NR-1:0]    i_rtr_ack;
    logic [NR*PW-1:0] o_out_bus;
    logic             o_busy;
    logic             o_bad_router;
    logic [7:0]       o_sent_cnt;
    logic             o_timeout;

    int n_checks;
    int n_errors;
    int exp_sent;

    noc_inject_scheduler #(
        .NR(NR), .PW(PW), .RW(RW), .DEPTH(4), .GAP_CYC(GAP), .TIMEOUT(64)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_req_valid  (i_req_valid),
        .i_req_router (i_req_router),
        .i_req_data   (i_req_data),
        .o_req_ready  (o_req_ready),
        .i_rtr_ack    (i_rtr_ack),
        .o_out_bus    (o_out_bus),
        .o_busy       (o_busy),
        .o_bad_router (o_bad_router),
        .o_sent_cnt   (o_sent_cnt),
        .o_timeout    (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Compare one observed value against its expected value and log a mismatch.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Expected bus image: valid flag + payload shifted into router slot r.
    function automatic logic [NR*PW-1:0] pkt(input int r, input logic [7:0] d);
        logic [NR*PW-1:0] v;
        v = {{(NR*PW-9){1'b0}}, 1'b1, d};
        return v << (r * PW);
    endfunction

    task automatic drive_req(input int r, input logic [7:0] d);
        i_req_valid  = 1'b1;
        i_req_router = RW'(r);
        i_req_data   = d;
        tick();
        i_req_valid  = 1'b0;
    endtask

    task automatic wait_bus(input string tag);
        int z;
        z = 0;
        while (o_out_bus == '0 && z < 20) begin
            z++;
            tick();
        end
        check(tag, (z < 20), 1);
    endtask

    task automatic wait_idle(input string tag);
        int z;
        z = 0;
        while (o_busy && z < 20) begin
            z++;
            tick();
        end
        check(tag, o_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int rt [4] = '{0, 8, 2, 5};
    logic [7:0] dt [4] = '{8'h10, 8'h11, 8'h12, 8'h13};

    initial begin
        int z;
        int n;
        int to_seen;
        n_checks = 0;
        n_errors = 0;
        exp_sent = 0;
        i_rst_n = 1'b0; i_en = 1'b0; i_req_valid = 1'b0;
        i_req_router = '0; i_req_data = '0; i_rtr_ack = '0;
        repeat (3) tick();

        // Reset state
        check("rst_bus", o_out_bus, 0);
        check("rst_sent", o_sent_cnt, 0);
        check("rst_ready", o_req_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_bad", o_bad_router, 0);
        check("rst_to", o_timeout, 0);
        i_rst_n = 1'b1;
        tick();

        // Single packet: latency c+2, hold, ack, gap, idle
        i_en = 1'b1;
        drive_req(3, 8'h21);
        check("t1_c1_bus", o_out_bus, 0);
        check("t1_c1_busy", o_busy, 1);
        tick();
        check("t1_c2_bus", o_out_bus, pkt(3, 8'h21));
        check("t1_c2_slice", o_out_bus[35:27], 9'h121);
        tick();
        check("t1_hold", o_out_bus, pkt(3, 8'h21));
        tick();
        check("t1_hold2", o_out_bus, pkt(3, 8'h21));
        i_rtr_ack = NR'(1) << 3;
        tick();
        i_rtr_ack = '0;
        exp_sent++;
        check("t1_clr", o_out_bus, 0);
        check("t1_sent", o_sent_cnt, exp_sent);
        check("t1_gap1_busy", o_busy, 1);
        tick();
        check("t1_gap2_bus", o_out_bus, 0);
        check("t1_gap2_busy", o_busy, 1);
        tick();
        check("t1_idle_busy", o_busy, 0);

        // Fill with en=0, fifth refused, then in-order service with gaps
        i_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t2_ready", o_req_ready, 1);
            drive_req(rt[k], dt[k]);
        end
        check("t2_full", o_req_ready, 0);
        drive_req(1, 8'hEE);
        check("t2_full2", o_req_ready, 0);
        check("t2_nolaunch", o_out_bus, 0);
        i_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            z = 0;
            while (o_out_bus == '0 && z < 20) begin
                z++;
                tick();
            end
            check("t2_wait", z, (k == 0) ? 1 : GAP + 1);
            check("t2_pkt", o_out_bus, pkt(rt[k], dt[k]));
            i_rtr_ack = NR'(1) << rt[k];
            tick();
            i_rtr_ack = '0;
            exp_sent++;
            check("t2_clr", o_out_bus, 0);
            check("t2_sent", o_sent_cnt, exp_sent);
        end
        wait_idle("t2_idle");
        tick();
        check("t2_no5th", o_out_bus, 0);

        // Out-of-range routers dropped with a pulse each
        i_req_valid = 1'b1; i_req_router = 4'd9; i_req_data = 8'hAA;
        tick();
        check("t3_bad9", o_bad_router, 1);
        i_req_router = 4'd15;
        tick();
        i_req_valid = 1'b0;
        check("t3_bad15", o_bad_router, 1);
        tick();
        check("t3_bad_end", o_bad_router, 0);
        check("t3_busy", o_busy, 0);
        check("t3_bus", o_out_bus, 0);
        tick();
        check("t3_bus2", o_out_bus, 0);

        // Wrong-router ack ignored
        drive_req(2, 8'h44);
        wait_bus("t4_wait");
        check("t4_pkt", o_out_bus, pkt(2, 8'h44));
        i_rtr_ack = NR'(1) << 5;
        repeat (3) tick();
        check("t4_held", o_out_bus, pkt(2, 8'h44));
        check("t4_sent_same", o_sent_cnt, exp_sent);
        i_rtr_ack = NR'(1) << 2;
        tick();
        i_rtr_ack = '0;
        exp_sent++;
        check("t4_clr", o_out_bus, 0);
        check("t4_sent", o_sent_cnt, exp_sent);
        wait_idle("t4_idle");

        // No ack: timeout when enabled, indefinite hold otherwise
        drive_req(7, 8'h77);
        wait_bus("t5_wait");
        check("t5_pkt", o_out_bus, pkt(7, 8'h77));
`ifdef NOC_INJ_TIMEOUT_EN
        n = 0;
        while (o_out_bus != '0 && n < 300) begin
            n++;
            tick();
        end
        check("t5_hold_len", n, 64);
        check("t5_to_pulse", o_timeout, 1);
        check("t5_sent_same", o_sent_cnt, exp_sent);
        tick();
        check("t5_to_end", o_timeout, 0);
        wait_idle("t5_idle");
`else
        to_seen = 0;
        repeat (200) begin
            tick();
            if (o_timeout) to_seen++;
        end
        check("t5_still", o_out_bus, pkt(7, 8'h77));
        check("t5_no_to", to_seen, 0);
        i_rtr_ack = NR'(1) << 7;
        tick();
        i_rtr_ack = '0;
        exp_sent++;
        check("t5_sent", o_sent_cnt, exp_sent);
        wait_idle("t5_idle");
`endif

        // Reset mid-packet with a partly filled queue
        drive_req(1, 8'h5A);
        wait_bus("t6_wait");
        check("t6_pkt", o_out_bus, pkt(1, 8'h5A));
        drive_req(4, 8'h01);
        drive_req(6, 8'h02);
        drive_req(8, 8'h03);
        check("t6_busy", o_busy, 1);
        check("t6_ready", o_req_ready, 1);
        i_rst_n = 1'b0;
        #2;
        check("t6_rst_bus", o_out_bus, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_sent", o_sent_cnt, 0);
        tick();
        i_rst_n = 1'b1;
        repeat (5) tick();
        check("t6_after_bus", o_out_bus, 0);
        check("t6_after_busy", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
